// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: idle-high, LSB-first frames of
// start bit 0, WIDTH data bits, optional parity bit and stop bit 1.
module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             dout,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    baud, baud_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic             par, par_n;
    logic             dout_n, busy_n, done_n;
    logic             accept, boundary;

    // A new word may be taken while idle or in the final stop-bit cycle,
    // which lets frames run back to back with no idle gap.
    assign load_ready = (state == IDLE || done) && rst;
    assign accept     = load_valid && load_ready;
    assign boundary   = (baud == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            dout    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            par     <= par_n;
            dout    <= dout_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par;
        dout_n    = dout;
        busy_n    = busy;

        if (state != IDLE) begin
            baud_n = boundary ? '0 : baud + CW'(1);
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = START;
                    dout_n  = 1'b0;
                    busy_n  = 1'b1;
                    baud_n  = '0;
                    par_n   = 1'b0;
                    shreg_n = load_data;
                end
            end
            START: begin
                if (boundary) begin
                    state_n   = DATA;
                    dout_n    = shreg[0];
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (boundary) begin
                    shreg_n   = shreg >> 1;
                    par_n     = par ^ shreg[0];
                    bit_cnt_n = bit_cnt + BW'(1);
                    if (bit_cnt == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            dout_n  = par_n ^ (PARITY_ODD != 0);
                        end else begin
                            state_n = STOP;
                            dout_n  = 1'b1;
                        end
                    end else begin
                        dout_n = shreg_n[0];
                    end
                end
            end
            PARITY: begin
                if (boundary) begin
                    state_n = STOP;
                    dout_n  = 1'b1;
                end
            end
            STOP: begin
                if (boundary) begin
                    if (accept) begin
                        state_n = START;
                        dout_n  = 1'b0;
                        busy_n  = 1'b1;
                        baud_n  = '0;
                        par_n   = 1'b0;
                        shreg_n = load_data;
                    end else begin
                        state_n = IDLE;
                        dout_n  = 1'b1;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                dout_n  = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    // done marks the last stop-bit cycle; with one clock per bit that is the
    // very cycle the stop bit is entered.
    assign done_n = (state_n == STOP) && (baud_n == BAUD_LAST);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: four configurations share one stimulus stream and
// are checked each cycle against a frame-level model plus literal expectations.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [7:0] load_data;
    logic [3:0] ready_v, dout_v, busy_v, done_v;

    int          vectors     = 0;
    int          miscompares = 0;
    bit          checking    = 1'b0;
    int          cyc         = 0;
    int          rem [4]     = '{0, 0, 0, 0};
    logic [19:0] fb  [4];

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_v[0]), .dout(dout_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_v[1]), .dout(dout_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    serial_frame_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_v[2]), .dout(dout_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    serial_frame_tx #(.WIDTH(5), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(1)) u3 (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data[4:0]),
        .load_ready(ready_v[3]), .dout(dout_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    function automatic int pw(input int i); return (i == 3) ? 5 : 8; endfunction
    function automatic int pc(input int i); return (i == 3) ? 1 : 4; endfunction
    function automatic int pe(input int i); return (i == 0) ? 0 : 1; endfunction
    function automatic int po(input int i); return (i >= 2) ? 1 : 0; endfunction

    function automatic int frameLen(input int i);
        return (2 + pw(i) + pe(i)) * pc(i);
    endfunction

    // Frame as a bit list in transmit order: start, data LSB first, parity, stop.
    function automatic logic [19:0] frameBits(input int i, input logic [7:0] d);
        logic [19:0] f;
        int ones;
        f    = '0;
        ones = 0;
        for (int k = 0; k < pw(i); k++) begin
            f[1 + k] = d[k];
            ones += int'(d[k]);
        end
        if (pe(i) != 0) f[1 + pw(i)] = ((ones % 2) ^ po(i)) != 0;
        f[1 + pw(i) + pe(i)] = 1'b1;
        return f;
    endfunction

    function automatic logic expDout(input int i);
        if (rem[i] == 0) return 1'b1;
        return fb[i][(frameLen(i) - rem[i]) / pc(i)];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d);
        load_valid = v;
        load_data  = d;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) stepCycle();
    endtask

    task automatic startFrame(input logic [7:0] d, input logic hold);
        applyStimulus(1'b1, d);
        stepCycle();
        cyc = 1;
        if (!hold) applyStimulus(1'b0, d);
    endtask

    task automatic toCycle(input int n);
        while (cyc < n) begin
            stepCycle();
            cyc++;
        end
        @(negedge clk);
    endtask

    // Model: remaining frame cycles per instance; a word is taken when the
    // model has at most the final stop cycle left.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst) begin
                rem[i] <= 0;
            end else if (load_valid && rem[i] <= 1) begin
                rem[i] <= frameLen(i);
                fb[i]  <= frameBits(i, load_data);
            end else if (rem[i] > 0) begin
                rem[i] <= rem[i] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("u%0d.dout", i), 32'(dout_v[i]), 32'(expDout(i)));
                checkOutput($sformatf("u%0d.busy", i), 32'(busy_v[i]), 32'(rem[i] != 0));
                checkOutput($sformatf("u%0d.done", i), 32'(done_v[i]), 32'(rem[i] == 1));
                checkOutput($sformatf("u%0d.ready", i), 32'(ready_v[i]),
                            32'(rst && rem[i] <= 1));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] cap;
        int dn, bz;

        rst = 1'b0;
        applyStimulus(1'b1, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checking = 1'b1;
            @(negedge clk);
            checkOutput("reset.dout", 32'(dout_v[0]), 32'd1);
            checkOutput("reset.busy", 32'(busy_v[0]), 32'd0);
            checkOutput("reset.done", 32'(done_v[0]), 32'd0);
            checkOutput("reset.ready", 32'(ready_v[0]), 32'd0);
        end
        stepCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00);
        @(negedge clk);
        checkOutput("release.ready", 32'(ready_v[0]), 32'd1);
        checkOutput("release.busy", 32'(busy_v[0]), 32'd0);
        stepCycle();
        @(negedge clk);
        checkOutput("release.nostart", 32'(busy_v[0]), 32'd0);

        // Basic frame 8'hA5
        startFrame(8'hA5, 1'b0);
        for (int b = 0; b < 10; b++) begin
            toCycle(4 * b + 2);
            cap[b] = dout_v[0];
        end
        checkOutput("a5.bits", 32'(cap), 32'(10'b1101001010));
        toCycle(39);
        checkOutput("a5.done39", 32'(done_v[0]), 32'd0);
        toCycle(40);
        checkOutput("a5.done40", 32'(done_v[0]), 32'd1);
        toCycle(41);
        checkOutput("a5.busy41", 32'(busy_v[0]), 32'd0);
        idleCycles(10);

        // Parity with 8'h07 (three ones)
        startFrame(8'h07, 1'b0);
        toCycle(2);
        checkOutput("u3.d0", 32'(dout_v[3]), 32'd1);
        toCycle(7);
        checkOutput("u3.parity", 32'(dout_v[3]), 32'd0);
        toCycle(8);
        checkOutput("u3.done8", 32'(done_v[3]), 32'd1);
        toCycle(38);
        checkOutput("even.parity", 32'(dout_v[1]), 32'd1);
        checkOutput("odd.parity", 32'(dout_v[2]), 32'd0);
        checkOutput("nopar.stop", 32'(dout_v[0]), 32'd1);
        toCycle(43);
        checkOutput("even.done43", 32'(done_v[1]), 32'd0);
        toCycle(44);
        checkOutput("even.done44", 32'(done_v[1]), 32'd1);
        checkOutput("odd.done44", 32'(done_v[2]), 32'd1);
        toCycle(45);
        checkOutput("even.busy45", 32'(busy_v[1]), 32'd0);
        idleCycles(10);

        // Back-to-back 8'h00 then 8'hFF with load_valid held
        startFrame(8'h00, 1'b1);
        applyStimulus(1'b1, 8'hFF);
        dn = 0;
        bz = 0;
        for (int n = 1; n <= 82; n++) begin
            toCycle(n);
            if (n <= 80 && !busy_v[0]) bz++;
            if (done_v[0]) dn++;
            if (n == 40) begin
                checkOutput("b2b.stop40", 32'(dout_v[0]), 32'd1);
                checkOutput("b2b.done40", 32'(done_v[0]), 32'd1);
            end
            if (n == 41) begin
                checkOutput("b2b.start41", 32'(dout_v[0]), 32'd0);
                checkOutput("b2b.busy41", 32'(busy_v[0]), 32'd1);
                applyStimulus(1'b0, 8'hFF);
            end
        end
        checkOutput("b2b.donecount", 32'(dn), 32'd2);
        checkOutput("b2b.busygaps", 32'(bz), 32'd0);
        checkOutput("b2b.busy82", 32'(busy_v[0]), 32'd0);
        idleCycles(10);

        // Reset during data bit 3 of 8'hA5, then 8'h3C
        startFrame(8'hA5, 1'b0);
        toCycle(18);
        rst = 1'b0;
        toCycle(19);
        checkOutput("midrst.dout", 32'(dout_v[0]), 32'd1);
        checkOutput("midrst.busy", 32'(busy_v[0]), 32'd0);
        checkOutput("midrst.ready", 32'(ready_v[0]), 32'd0);
        rst = 1'b1;
        idleCycles(3);
        startFrame(8'h3C, 1'b0);
        for (int b = 0; b < 10; b++) begin
            toCycle(4 * b + 2);
            cap[b] = dout_v[0];
        end
        checkOutput("3c.bits", 32'(cap), 32'(10'b1001111000));
        toCycle(41);
        checkOutput("3c.busy41", 32'(busy_v[0]), 32'd0);
        idleCycles(10);

        // Ignored inputs: data change after accept and a mid-frame valid pulse
        startFrame(8'h96, 1'b0);
        applyStimulus(1'b0, 8'h55);
        dn = 0;
        bz = 0;
        for (int n = 1; n <= 60; n++) begin
            toCycle(n);
            if (n % 4 == 2 && n <= 38) cap[(n - 2) / 4] = dout_v[0];
            if (done_v[0]) dn++;
            if (n > 40 && busy_v[0]) bz++;
            if (n == 10) applyStimulus(1'b1, 8'h55);
            if (n == 11) applyStimulus(1'b0, 8'h55);
        end
        checkOutput("96.bits", 32'(cap), 32'(10'b1100101100));
        checkOutput("96.donecount", 32'(dn), 32'd1);
        checkOutput("96.nosecond", 32'(bz), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
